// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizing constants and FSM state type for the round-robin mux arbiter.
package mux_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W = 2;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin search starting at rr_ptr; the first requesting index wins.
module rr_pick import mux_arb_pkg::*; (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   rr_ptr,
  output logic               found,
  output logic [SEL_W-1:0]   index
);
  always_comb begin
    found = 1'b0;
    index = rr_ptr;
    // Walk from the farthest offset down so the nearest requester overrides.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[rr_ptr + SEL_W'(k)]) begin
        found = 1'b1;
        index = rr_ptr + SEL_W'(k);
      end
    end
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: 4-way round-robin arbiter with burst limit driving a registered 4:1 data mux.
module mux_rr_arbiter import mux_arb_pkg::*; #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]             grant,
  output logic [SEL_W-1:0]               sel,
  output logic [DATA_W-1:0]              data_out,
  output logic                           valid_out,
  output logic                           busy
);
  state_t state, state_nxt;
  logic [SEL_W-1:0] rr_ptr, ptr_nxt, pick_ptr, pick_idx, sel_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic found, beat, rel, valid_nxt;

  assign beat = state == GRANT && req[sel];
  assign rel = state == GRANT && (!beat || cnt == 8'(MAX_BURST));
  // On release the search starts just past the owner, so the owner is considered last.
  assign pick_ptr = rel ? sel + SEL_W'(1) : rr_ptr;

  rr_pick u_pick (
    .req    (req),
    .rr_ptr (pick_ptr),
    .found  (found),
    .index  (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    sel_nxt = sel;
    cnt_nxt = cnt;
    ptr_nxt = rr_ptr;
    valid_nxt = beat;
    data_nxt = beat ? data_in[sel] : data_out;
    if (state == IDLE || rel) begin
      ptr_nxt = pick_ptr;
      state_nxt = found ? GRANT : IDLE;
      sel_nxt = found ? pick_idx : sel;
      cnt_nxt = found ? 8'd1 : cnt;
    end else begin
      cnt_nxt = cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      cnt <= '0;
      rr_ptr <= '0;
      valid_out <= 1'b0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      sel <= sel_nxt;
      cnt <= cnt_nxt;
      rr_ptr <= ptr_nxt;
      valid_out <= valid_nxt;
      data_out <= data_nxt;
    end
  end

  assign busy = state == GRANT;
  assign grant = busy ? NUM_REQ'(1) << sel : '0;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed and random checks of two arbiter instances (burst 4 and burst 1) against a behavioural model.
module tb_mux_rr_arbiter;
  logic clk = 0, rst_n = 0;
  logic [3:0] req = '0;
  logic [3:0][7:0] data_in = '0;
  logic [3:0] grant0, grant1;
  logic [1:0] sel0, sel1;
  logic [7:0] data0, data1;
  logic valid0, valid1, busy0, busy1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .grant(grant0),
    .sel(sel0), .data_out(data0), .valid_out(valid0), .busy(busy0)
  );
  mux_rr_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .grant(grant1),
    .sel(sel1), .data_out(data1), .valid_out(valid1), .busy(busy1)
  );

  wire [15:0] act0 = {grant0, sel0, busy0, valid0, data0};
  wire [15:0] act1 = {grant1, sel1, busy1, valid1, data1};

  // Model: owner, beats taken in the current grant, next search start.
  bit m_busy[2], m_valid[2];
  int m_owner[2], m_beats[2], m_ptr[2];
  logic [7:0] m_data[2];

  function automatic int pick(int ptr, logic [3:0] r);
    for (int k = 0; k < 4; k++) if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [15:0] exp_vec(int i);
    logic [3:0] g;
    g = m_busy[i] ? 4'(1 << m_owner[i]) : 4'b0;
    return {g, 2'(m_owner[i]), m_busy[i], m_valid[i], m_data[i]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 0; m_valid[i] = 0; m_owner[i] = 0; m_beats[i] = 0; m_ptr[i] = 0; m_data[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int w, lim;
        lim = i == 0 ? 4 : 1;
        if (!m_busy[i]) begin
          m_valid[i] = 0;
          w = pick(m_ptr[i], req);
          if (w >= 0) begin m_busy[i] = 1; m_owner[i] = w; m_beats[i] = 0; end
        end else begin
          m_valid[i] = req[m_owner[i]];
          if (m_valid[i]) begin m_data[i] = data_in[m_owner[i]]; m_beats[i]++; end
          if (!m_valid[i] || m_beats[i] == lim) begin
            m_ptr[i] = (m_owner[i] + 1) % 4;
            w = pick(m_ptr[i], req);
            if (w >= 0) begin m_owner[i] = w; m_beats[i] = 0; end
            else m_busy[i] = 0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 0;
    req = '0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (act0 !== 16'h0) begin errors++; $display("FAIL reset0: got %h expected %h", act0, 16'h0); end
    checks++; if (act1 !== 16'h0) begin errors++; $display("FAIL reset1: got %h expected %h", act1, 16'h0); end
    rst_n = 1;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    data_in = {8'h00, 8'h00, 8'h00, 8'hA5};
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checks++; if (act0 !== exp_vec(0)) begin errors++; $display("FAIL single c%0d: got %h expected %h", c, act0, exp_vec(0)); end
      if (c == 1) begin
        checks++; if ({grant0, valid0} !== 5'b0001_0) begin errors++; $display("FAIL single_first: got %b expected %b", {grant0, valid0}, 5'b0001_0); end
      end else begin
        checks++; if ({grant0, valid0, data0} !== {4'b0001, 1'b1, 8'hA5}) begin errors++; $display("FAIL single_beat c%0d: got %h expected %h", c, {grant0, valid0, data0}, {4'b0001, 1'b1, 8'hA5}); end
      end
    end
  endtask

  task automatic test_all();
    int l;
    do_reset();
    req = 4'b1111;
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      checks++; if (act0 !== exp_vec(0)) begin errors++; $display("FAIL all c%0d: got %h expected %h", c, act0, exp_vec(0)); end
      checks++; if (sel0 !== 2'(((c - 1) / 4) % 4)) begin errors++; $display("FAIL all_sel c%0d: got %0d expected %0d", c, sel0, ((c - 1) / 4) % 4); end
      if (c >= 2) begin
        l = ((c - 2) / 4) % 4;
        checks++; if ({valid0, data0} !== {1'b1, data_in[l]}) begin errors++; $display("FAIL all_data c%0d: got %h expected %h", c, {valid0, data0}, {1'b1, data_in[l]}); end
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0110;
    @(negedge clk);
    checks++; if (grant0 !== 4'b0010) begin errors++; $display("FAIL drop_first: got %b expected %b", grant0, 4'b0010); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (act0 !== exp_vec(0)) begin errors++; $display("FAIL drop c%0d: got %h expected %h", c, act0, exp_vec(0)); end
    end
    req = 4'b0100;
    @(negedge clk);
    checks++; if ({grant0, sel0} !== {4'b0100, 2'd2}) begin errors++; $display("FAIL drop_switch: got %h expected %h", {grant0, sel0}, {4'b0100, 2'd2}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0110;
    @(negedge clk);
    @(negedge clk);
    req = 4'b0100;
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    checks++; if (act0 !== 16'h0) begin errors++; $display("FAIL midreset_async: got %h expected %h", act0, 16'h0); end
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    checks++; if (act0 !== 16'h0) begin errors++; $display("FAIL midreset_hold: got %h expected %h", act0, 16'h0); end
    @(negedge clk);
    checks++; if ({grant0, sel0, busy0} !== {4'b0100, 2'd2, 1'b1}) begin errors++; $display("FAIL midreset_regrant: got %h expected %h", {grant0, sel0, busy0}, {4'b0100, 2'd2, 1'b1}); end
  endtask

  task automatic test_burst1();
    do_reset();
    req = 4'b1010;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if (act1 !== exp_vec(1)) begin errors++; $display("FAIL burst1 c%0d: got %h expected %h", c, act1, exp_vec(1)); end
      checks++; if ({sel1, valid1} !== {(c % 2) ? 2'd1 : 2'd3, c >= 2}) begin errors++; $display("FAIL burst1_sel c%0d: got %h expected %h", c, {sel1, valid1}, {(c % 2) ? 2'd1 : 2'd3, c >= 2}); end
    end
  endtask

  task automatic test_nongrant();
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (grant0 !== 4'b0001) begin errors++; $display("FAIL nongrant c%0d: got %b expected %b", c, grant0, 4'b0001); end
      req[3] = ~req[3];
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      for (int l = 0; l < 4; l++) data_in[l] = 8'($urandom);
      @(negedge clk);
      checks++; if (act0 !== exp_vec(0)) begin errors++; $display("FAIL rand0 c%0d: got %h expected %h", c, act0, exp_vec(0)); end
      checks++; if (act1 !== exp_vec(1)) begin errors++; $display("FAIL rand1 c%0d: got %h expected %h", c, act1, exp_vec(1)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all();
    test_drop();
    test_reset_mid();
    test_burst1();
    test_nongrant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
